fpnew_result_reorder: RTL and testbench
=======================================

Name: fpnew_result_reorder

Overview:
- Consumer end of the FP opgroup result handshake.
- Allocates in-order slot indices that the issue logic sends down as the operation tag.
- Accepts results that come back out of order from format slices of differing latency, keyed by that index.
- Retires results strictly in allocation order to the register-file writeback port.

Parameters:
- Width, 32: result data width in bits.
- Depth, 4: number of reorder slots. Power of two, ≥2.
- IdxWidth, $clog2(Depth): slot index width. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all slots
- alloc_valid_i  in  1  issue requests a slot
- alloc_ready_o  out  1  slot available
- alloc_idx_o  out  IdxWidth  index granted; used as the op tag
- res_valid_i  in  1  result valid from opgroup output
- res_ready_o  out  1  result accept; tied 1
- res_idx_i  in  IdxWidth  tag of the returning result
- res_result_i  in  Width  result data
- res_status_i  in  5  fpnew_pkg::status_t flags {NV,DZ,OF,UF,NX}
- res_ext_bit_i  in  1  extension bit
- out_valid_o  out  1  head slot complete
- out_ready_i  in  1  writeback accepts
- out_idx_o  out  IdxWidth  retiring slot index
- out_result_o  out  Width  retiring data
- out_status_o  out  5  retiring flags
- out_ext_bit_o  out  1  retiring extension bit
- count_o  out  IdxWidth+1  allocated slots (PENDING + DONE)
- err_o  out  1  one-cycle pulse: result hit a non-PENDING slot
- busy_o  out  1  count_o != 0

Behaviour:
- Per-slot state: FREE→PENDING (on alloc), PENDING→DONE (on result), DONE→FREE (on retire).
- Pointers: head_q and tail_q, each IdxWidth+1 bits; the MSB is the wrap bit.
  - empty = (head_q == tail_q).
  - full = index bits equal and wrap bits differ.
- Allocation:
  - alloc_ready_o = !full. Registered state only; no combinational path from out_ready_i.
  - alloc_idx_o = tail_q[IdxWidth-1:0].
  - On alloc_valid_i && alloc_ready_o: slot becomes PENDING and tail_q increments (mod 2·Depth).
- Result write:
  - On res_valid_i with slot[res_idx_i] == PENDING: data, flags and ext bit are latched; slot becomes DONE next cycle.
  - If the slot is FREE or DONE: the write is dropped, data is unchanged, and err_o = 1 the next cycle.
- Retire:
  - out_valid_o = (slot[head] == DONE). The out_* data come from slot registers.
  - Minimum latency from result to out_valid_o is 1 cycle.
  - On out_valid_o && out_ready_i: slot becomes FREE and head_q increments.
  - While out_valid_o is high and out_ready_i is low, all out_* values hold stable.
- Simultaneous events in one cycle:
  - Alloc + retire: both are performed; count_o is unchanged.
  - When full, alloc stays blocked that cycle even if a retire occurs; the freed slot is visible next cycle.
  - Result for the head slot + retire of the head: impossible, because the head is not DONE yet.
  - Result + alloc targeting the same index: impossible, because the slot is not FREE.
- count_o = tail_q − head_q (IdxWidth+1 bits).
- Flush (flush_i = 1):
  - Next cycle: all slots FREE, head_q = tail_q = 0.
  - Alloc, result and retire in the flush cycle are all ignored; err_o is not raised.
  - out_valid_o is forced 0 in the flush cycle.
- Reset values: all slots FREE, head_q = tail_q = 0, alloc_ready_o = 1, out_valid_o = 0, err_o = 0, count_o = 0, busy_o = 0, out_* data = 0.
  - Reset mid-operation discards everything, identical to flush.
- Priority: rst_i > flush_i > normal operation.

Optional Feature:
- Macro: FPNEW_REORDER_BYPASS_EN.
- Defined: a valid result whose res_idx_i == head index and whose slot is PENDING drives out_valid_o and out_* combinationally in the same cycle.
  - If out_ready_i is also 1, the slot retires directly (PENDING→FREE) and is never stored.
  - Otherwise it is stored as DONE as normal.
  - Latency 0.
- Undefined: no combinational res→out path; latency 1.

Test Plan:
- Reset, then alloc 4 in consecutive cycles → alloc_idx_o = 0, 1, 2, 3; alloc_ready_o = 0 after the 4th; count_o = 4.
- Results returned in order idx 2, 0, 3, 1 with data 0xC, 0xA, 0xD, 0xB, out_ready_i = 1 → retires 0xA, 0xB, 0xC, 0xD with out_idx_o = 0, 1, 2, 3. No output before idx 0 arrives.
- Full buffer, head DONE, out_ready_i = 1 with alloc_valid_i = 1 → retire occurs, alloc blocked that cycle, alloc granted next cycle with idx 0 (wrap); count_o 4→3→4.
- Result to a FREE slot idx 1 after reset → err_o pulses 1 for exactly one cycle, no state change, out_valid_o stays 0.
- Hold out_ready_i = 0 for 3 cycles with head DONE (data 0x3F800000, status NX = 1) → out_* stable across all 3 cycles; retires on the first cycle out_ready_i = 1.
- 3 slots allocated, 1 DONE; assert flush_i together with a result → next cycle count_o = 0, out_valid_o = 0, err_o = 0; next alloc gets idx 0.
- (With FPNEW_REORDER_BYPASS_EN) result to head with out_ready_i = 1 → out_valid_o in the same cycle; count_o drops by 1 next cycle.

Source files
------------

// File: rtl/fpnew_result_reorder.sv
// fpnew_result_reorder
//   Reorder buffer at the consumer end of the FP opgroup result handshake.
//   Issue logic allocates slot indices in order and sends them down as the
//   operation tag. Results come back out of order, keyed by that tag, and
//   retire strictly in allocation order to the writeback port.
//
//   Optional feature macro: FPNEW_REORDER_BYPASS_EN
//     When defined, a result for the PENDING head slot is presented on out_*
//     in the same cycle. If out_ready_i is also high, that slot retires
//     directly and is never stored.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             discard all slots (ignores alloc/result/retire)
//   alloc_valid_i/_ready_o, alloc_idx_o   in-order slot allocation
//   res_valid_i/_ready_o, res_idx_i, res_result_i, res_status_i,
//   res_ext_bit_i       returning (out-of-order) results
//   out_valid_o/out_ready_i, out_idx_o, out_result_o, out_status_o,
//   out_ext_bit_o       in-order retire to writeback
//   count_o             allocated slots (PENDING + DONE)
//   err_o               one-cycle pulse: result hit a non-PENDING slot
//   busy_o              count_o != 0
module fpnew_result_reorder #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdxWidth = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  output logic [IdxWidth-1:0] alloc_idx_o,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic [IdxWidth-1:0] res_idx_i,
  input  logic [Width-1:0]    res_result_i,
  input  logic [4:0]          res_status_i,
  input  logic                res_ext_bit_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [IdxWidth-1:0] out_idx_o,
  output logic [Width-1:0]    out_result_o,
  output logic [4:0]          out_status_o,
  output logic                out_ext_bit_o,
  output logic [IdxWidth:0]   count_o,
  output logic                err_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PENDING,
    SLOT_DONE
  } slot_e;

  localparam logic [IdxWidth:0] PtrOne = {{IdxWidth{1'b0}}, 1'b1};

  slot_e               state_q  [Depth];
  logic [Width-1:0]    data_q   [Depth];
  logic [4:0]          status_q [Depth];
  logic                ext_q    [Depth];

  logic [IdxWidth:0]   head_q, head_d;
  logic [IdxWidth:0]   tail_q, tail_d;
  logic                err_q, err_d;

  logic [IdxWidth-1:0] head_idx, tail_idx;
  logic                full;
  logic                res_pending;
  logic                stored_valid;
  logic                bypass_hit;
  logic                alloc_fire;
  logic                res_write;
  logic                retire_fire;

  assign head_idx = head_q[IdxWidth-1:0];
  assign tail_idx = tail_q[IdxWidth-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IdxWidth] != tail_q[IdxWidth]);

  assign alloc_ready_o = !full;
  assign alloc_idx_o   = tail_idx;
  assign res_ready_o   = 1'b1;
  assign count_o       = tail_q - head_q;
  assign busy_o        = (count_o != '0);
  assign err_o         = err_q;
  assign out_idx_o     = head_idx;

  always_comb begin
    res_pending  = (state_q[res_idx_i] == SLOT_PENDING);
    stored_valid = (state_q[head_idx] == SLOT_DONE);
    bypass_hit   = 1'b0;
`ifdef FPNEW_REORDER_BYPASS_EN
    // Head can only be PENDING here, so this never overlaps stored_valid.
    bypass_hit   = res_valid_i && res_pending && (res_idx_i == head_idx);
`endif
    out_valid_o   = !flush_i && (stored_valid || bypass_hit);
    out_result_o  = bypass_hit ? res_result_i  : data_q[head_idx];
    out_status_o  = bypass_hit ? res_status_i  : status_q[head_idx];
    out_ext_bit_o = bypass_hit ? res_ext_bit_i : ext_q[head_idx];

    alloc_fire  = alloc_valid_i && !full && !flush_i;
    retire_fire = out_valid_o && out_ready_i;
    // A bypassed result that retires immediately is not written into its slot.
    res_write   = res_valid_i && res_pending && !flush_i && !(bypass_hit && out_ready_i);
    err_d       = res_valid_i && !res_pending && !flush_i;

    head_d = retire_fire ? head_q + PtrOne : head_q;
    tail_d = alloc_fire  ? tail_q + PtrOne : tail_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        state_q[i[IdxWidth-1:0]]  <= SLOT_FREE;
        data_q[i[IdxWidth-1:0]]   <= '0;
        status_q[i[IdxWidth-1:0]] <= '0;
        ext_q[i[IdxWidth-1:0]]    <= 1'b0;
      end
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        state_q[i[IdxWidth-1:0]] <= SLOT_FREE;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      // Alloc, result and retire always address distinct slots, except a
      // bypassed result retiring in the same cycle, where retire wins.
      if (alloc_fire) begin
        state_q[tail_idx] <= SLOT_PENDING;
      end
      if (res_write) begin
        state_q[res_idx_i]  <= SLOT_DONE;
        data_q[res_idx_i]   <= res_result_i;
        status_q[res_idx_i] <= res_status_i;
        ext_q[res_idx_i]    <= res_ext_bit_i;
      end
      if (retire_fire) begin
        state_q[head_idx] <= SLOT_FREE;
      end
    end
  end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
module tb_fpnew_result_reorder;

  localparam int unsigned Width    = 32;
  localparam int unsigned Depth    = 4;
  localparam int unsigned IdxWidth = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                alloc_valid;
  logic                alloc_ready;
  logic [IdxWidth-1:0] alloc_idx;
  logic                res_valid;
  logic                res_ready;
  logic [IdxWidth-1:0] res_idx;
  logic [Width-1:0]    res_result;
  logic [4:0]          res_status;
  logic                res_ext;
  logic                out_valid;
  logic                out_ready;
  logic [IdxWidth-1:0] out_idx;
  logic [Width-1:0]    out_result;
  logic [4:0]          out_status;
  logic                out_ext;
  logic [IdxWidth:0]   count;
  logic                err;
  logic                busy;

  int errors = 0;
  int checks = 0;

  fpnew_result_reorder #(.Width(Width), .Depth(Depth)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .alloc_valid_i (alloc_valid),
    .alloc_ready_o (alloc_ready),
    .alloc_idx_o   (alloc_idx),
    .res_valid_i   (res_valid),
    .res_ready_o   (res_ready),
    .res_idx_i     (res_idx),
    .res_result_i  (res_result),
    .res_status_i  (res_status),
    .res_ext_bit_i (res_ext),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_idx_o     (out_idx),
    .out_result_o  (out_result),
    .out_status_o  (out_status),
    .out_ext_bit_o (out_ext),
    .count_o       (count),
    .err_o         (err),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send(input logic [IdxWidth-1:0] idx, input logic [Width-1:0] d,
                      input logic [4:0] st, input logic e);
    res_valid  = 1'b1;
    res_idx    = idx;
    res_result = d;
    res_status = st;
    res_ext    = e;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; res_valid = 1'b0;
    res_idx = '0; res_result = '0; res_status = '0; res_ext = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; settle();

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("res_ready_tied", 64'(res_ready), 64'd1);

    // Allocate 4 in consecutive cycles
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("alloc_idx", 64'(alloc_idx), 64'(i));
      chk("alloc_ready_pre", 64'(alloc_ready), 64'd1);
      tick();
    end
    alloc_valid = 1'b0; settle();
    chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_busy", 64'(busy), 64'd1);

    // Out-of-order results 2,0,3,1 with in-order retire
    out_ready = 1'b1;
    send(2'd2, 32'hC, 5'd0, 1'b0); settle();
    chk("ooo_wait_a", 64'(out_valid), 64'd0);
    tick();
    send(2'd0, 32'hA, 5'd0, 1'b0); settle();
    chk("ooo_wait_b", 64'(out_valid), 64'd0);
    tick();
    send(2'd3, 32'hD, 5'd0, 1'b0); settle();
    chk("ret0_valid", 64'(out_valid), 64'd1);
    chk("ret0_idx", 64'(out_idx), 64'd0);
    chk("ret0_data", 64'(out_result), 64'hA);
    tick();
    send(2'd1, 32'hB, 5'd0, 1'b0); settle();
    chk("ooo_wait_head1", 64'(out_valid), 64'd0);
    tick();
    res_valid = 1'b0; settle();
    chk("ret1_valid", 64'(out_valid), 64'd1);
    chk("ret1_idx", 64'(out_idx), 64'd1);
    chk("ret1_data", 64'(out_result), 64'hB);
    tick(); settle();
    chk("ret2_idx", 64'(out_idx), 64'd2);
    chk("ret2_data", 64'(out_result), 64'hC);
    tick(); settle();
    chk("ret3_idx", 64'(out_idx), 64'd3);
    chk("ret3_data", 64'(out_result), 64'hD);
    tick(); settle();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_err", 64'(err), 64'd0);

    // Full with head DONE: retire + blocked alloc, then wrap grant idx 0
    out_ready = 1'b0;
    alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("wrap_alloc_idx", 64'(alloc_idx), 64'(i));
      if (i == 3) send(2'd0, 32'h11, 5'd0, 1'b0);
      tick();
    end
    res_valid = 1'b0;
    out_ready = 1'b1; settle();
    chk("wrap_blocked_ready", 64'(alloc_ready), 64'd0);
    chk("wrap_head_valid", 64'(out_valid), 64'd1);
    chk("wrap_head_data", 64'(out_result), 64'h11);
    chk("wrap_count4", 64'(count), 64'd4);
    tick(); settle();
    chk("wrap_count3", 64'(count), 64'd3);
    chk("wrap_ready_after", 64'(alloc_ready), 64'd1);
    chk("wrap_idx0", 64'(alloc_idx), 64'd0);
    chk("wrap_no_valid", 64'(out_valid), 64'd0);
    tick();
    alloc_valid = 1'b0; settle();
    chk("wrap_count4b", 64'(count), 64'd4);

    // Reset mid-operation, then result to a FREE slot
    rst = 1'b1; tick(); rst = 1'b0; settle();
    chk("rst2_count", 64'(count), 64'd0);
    send(2'd1, 32'h55, 5'd0, 1'b0); settle();
    chk("errfree_pre", 64'(err), 64'd0);
    tick();
    res_valid = 1'b0; settle();
    chk("errfree_pulse", 64'(err), 64'd1);
    chk("errfree_valid", 64'(out_valid), 64'd0);
    chk("errfree_count", 64'(count), 64'd0);
    tick(); settle();
    chk("errfree_clear", 64'(err), 64'd0);
    chk("errfree_valid2", 64'(out_valid), 64'd0);

    // Backpressure hold on head DONE
    out_ready = 1'b0;
    alloc_valid = 1'b1; tick();
    alloc_valid = 1'b0;
    send(2'd0, 32'h3F800000, 5'b00001, 1'b1); tick();
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_idx", 64'(out_idx), 64'd0);
      chk("hold_data", 64'(out_result), 64'h3F800000);
      chk("hold_status", 64'(out_status), 64'h01);
      chk("hold_ext", 64'(out_ext), 64'd1);
      tick();
    end
    out_ready = 1'b1; settle();
    chk("hold_release_valid", 64'(out_valid), 64'd1);
    tick(); settle();
    chk("hold_retired_valid", 64'(out_valid), 64'd0);
    chk("hold_retired_count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Flush with 3 allocated, 1 DONE, plus a concurrent result
    alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fl_alloc_idx", 64'(alloc_idx), 64'(i + 1));
      tick();
    end
    alloc_valid = 1'b0;
    send(2'd1, 32'h77, 5'd0, 1'b0); tick();
    send(2'd2, 32'h88, 5'd0, 1'b0);
    flush = 1'b1; settle();
    chk("fl_cycle_valid", 64'(out_valid), 64'd0);
    chk("fl_pre_count", 64'(count), 64'd3);
    tick();
    flush = 1'b0; res_valid = 1'b0; settle();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_err", 64'(err), 64'd0);
    chk("fl_next_idx", 64'(alloc_idx), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);

`ifdef FPNEW_REORDER_BYPASS_EN
    // Bypass: result to PENDING head retires in the same cycle
    alloc_valid = 1'b1; tick();
    alloc_valid = 1'b0; settle();
    chk("byp_count1", 64'(count), 64'd1);
    out_ready = 1'b1;
    send(2'd0, 32'h99, 5'b00100, 1'b0); settle();
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_data", 64'(out_result), 64'h99);
    chk("byp_status", 64'(out_status), 64'h04);
    tick();
    res_valid = 1'b0; settle();
    chk("byp_count0", 64'(count), 64'd0);
    chk("byp_after_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
`else
    // No bypass: result to PENDING head is visible one cycle later
    alloc_valid = 1'b1; tick();
    alloc_valid = 1'b0;
    out_ready = 1'b1;
    send(2'd0, 32'h99, 5'b00100, 1'b0); settle();
    chk("lat1_same_cycle", 64'(out_valid), 64'd0);
    tick();
    res_valid = 1'b0; settle();
    chk("lat1_valid", 64'(out_valid), 64'd1);
    chk("lat1_data", 64'(out_result), 64'h99);
    tick(); settle();
    chk("lat1_count0", 64'(count), 64'd0);
    out_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
